// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
//   Shares the single write port of the 32x64 register file between NREQ
//   writeback sources. Grants are round-robin, use a valid/ready handshake
//   per source, and pass through one registered output stage that drives the
//   regfile write port directly. Writes to X31, the hard-wired zero register,
//   are accepted but never reach the regfile; they are counted instead.
//
// Ports
//   clk            rising-edge clock
//   rst_n          synchronous reset, active-low
//   arb_en         1 = new grants allowed, 0 = freeze (registered write still commits)
//   req_valid      [NREQ]     requester i has a pending write
//   req_reg        [NREQ*AW]  destination index of requester i at [i*AW +: AW]
//   req_data       [NREQ*DW]  write data of requester i at [i*DW +: DW]
//   req_ready      [NREQ]     one-hot grant; a transfer is valid & ready
//   RegWrite       regfile write enable
//   WriteRegister  regfile write index
//   WriteData      regfile write data
//   zero_drop_cnt  saturating count of accepted writes to X31
module regfile_write_arbiter #(
  parameter int NREQ = 3,
  parameter int DW   = 64,
  parameter int AW   = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 arb_en,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*AW-1:0]   req_reg,
  input  logic [NREQ*DW-1:0]   req_data,
  output logic [NREQ-1:0]      req_ready,
  output logic                 RegWrite,
  output logic [AW-1:0]        WriteRegister,
  output logic [DW-1:0]        WriteData,
  output logic [15:0]          zero_drop_cnt
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [AW-1:0] ZERO_REG = AW'(31);

  logic [PW-1:0]   ptr_reg, ptr_next;
  logic [NREQ-1:0] grant;
  logic [PW-1:0]   grant_idx;
  logic            xfer;
  logic            zero_hit;
  logic [AW-1:0]   sel_reg;
  logic [DW-1:0]   sel_data;

  logic            regwrite_reg;
  logic [AW-1:0]   wreg_reg;
  logic [DW-1:0]   wdata_reg;
  logic [15:0]     zcnt_reg;

  // Rotating priority scan: offset k from the pointer is tried in order, the
  // first valid requester found wins. At most one grant bit can be set.
  always_comb begin
    int  idx;
    logic found;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr_reg) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      for (int i = 0; i < NREQ; i++) begin
        if (!found && (i == idx) && req_valid[i]) begin
          grant[i]  = 1'b1;
          grant_idx = PW'(i);
          found     = 1'b1;
        end
      end
    end
  end

  assign req_ready = (rst_n && arb_en) ? grant : '0;
  assign xfer      = |req_ready;

  // Each requester's fields are masked by its own ready bit before being
  // OR-ed together, so unknown values on non-granted inputs cannot leak
  // into the selected write.
  logic [AW-1:0] reg_masked  [NREQ];
  logic [DW-1:0] data_masked [NREQ];

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_mask
      assign reg_masked[gi]  = req_reg[gi*AW +: AW]  & {AW{req_ready[gi]}};
      assign data_masked[gi] = req_data[gi*DW +: DW] & {DW{req_ready[gi]}};
    end
  endgenerate

  always_comb begin
    sel_reg  = '0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      sel_reg  = sel_reg  | reg_masked[i];
      sel_data = sel_data | data_masked[i];
    end
  end

  assign zero_hit = xfer && (sel_reg == ZERO_REG);

  // The pointer moves just past whoever was served, so every valid
  // requester is reached within NREQ grants.
  always_comb begin
    ptr_next = ptr_reg;
    if (xfer) begin
      if (grant_idx == PW'(NREQ - 1)) ptr_next = '0;
      else                            ptr_next = grant_idx + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_reg      <= '0;
      regwrite_reg <= 1'b0;
      wreg_reg     <= '0;
      wdata_reg    <= '0;
      zcnt_reg     <= '0;
    end else begin
      ptr_reg      <= ptr_next;
      regwrite_reg <= xfer && !zero_hit;
      // Index/data only move on a real write; otherwise they hold.
      if (xfer && !zero_hit) begin
        wreg_reg  <= sel_reg;
        wdata_reg <= sel_data;
      end
      if (zero_hit && (zcnt_reg != 16'hFFFF)) begin
        zcnt_reg <= zcnt_reg + 16'd1;
      end
    end
  end

  // A write still sitting in the output stage when reset arrives must not
  // commit at that edge, so the enable is also qualified by rst_n.
  assign RegWrite      = regwrite_reg & rst_n;
  assign WriteRegister = wreg_reg;
  assign WriteData     = wdata_reg;
  assign zero_drop_cnt = zcnt_reg;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Testbench for regfile_write_arbiter: directed scenarios plus a randomized
// run, all checked against a behavioural model of the arbiter rules.
module tb_regfile_write_arbiter;

  localparam int NREQ = 3;
  localparam int DW   = 64;
  localparam int AW   = 5;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                arb_en = 1'b1;
  logic [NREQ-1:0]     req_valid = '0;
  logic [NREQ*AW-1:0]  req_reg = '0;
  logic [NREQ*DW-1:0]  req_data = '0;
  logic [NREQ-1:0]     req_ready;
  logic                RegWrite;
  logic [AW-1:0]       WriteRegister;
  logic [DW-1:0]       WriteData;
  logic [15:0]         zero_drop_cnt;

  int n_cmp = 0;
  int n_err = 0;

  regfile_write_arbiter #(.NREQ(NREQ), .DW(DW), .AW(AW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .arb_en        (arb_en),
    .req_valid     (req_valid),
    .req_reg       (req_reg),
    .req_data      (req_data),
    .req_ready     (req_ready),
    .RegWrite      (RegWrite),
    .WriteRegister (WriteRegister),
    .WriteData     (WriteData),
    .zero_drop_cnt (zero_drop_cnt)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural reference model ----------------
  int          m_ptr = 0;
  bit          m_we  = 1'b0;
  logic [4:0]  m_wr  = '0;
  logic [63:0] m_wd  = '0;
  int          m_cnt = 0;

  // Expected grant: first valid requester scanning ptr, ptr+1, ... mod NREQ.
  function automatic logic [NREQ-1:0] model_ready();
    logic [NREQ-1:0] r;
    int i;
    r = '0;
    if (rst_n === 1'b1 && arb_en === 1'b1) begin
      for (int k = 0; k < NREQ; k++) begin
        i = (m_ptr + k) % NREQ;
        if (req_valid[i]) begin
          r[i] = 1'b1;
          return r;
        end
      end
    end
    return r;
  endfunction

  always @(posedge clk) begin
    logic [NREQ-1:0] g;
    logic [4:0] r;
    g = model_ready();
    if (rst_n !== 1'b1) begin
      m_ptr = 0; m_we = 1'b0; m_wr = '0; m_wd = '0; m_cnt = 0;
    end else begin
      m_we = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
        if (g[i]) begin
          m_ptr = (i + 1) % NREQ;
          r = req_reg[i*AW +: AW];
          $display("xfer t=%0t req=%0d reg=%0d data=%h", $time, i, r, req_data[i*DW +: DW]);
          if (r == 5'd31) begin
            if (m_cnt < 65535) m_cnt = m_cnt + 1;
          end else begin
            m_we = 1'b1;
            m_wr = r;
            m_wd = req_data[i*DW +: DW];
          end
        end
      end
    end
  end

  // ---------------- stimulus helpers (no checks) ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req_valid = '0; arb_en = 1'b1;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0; arb_en = 1'b1; req_valid = '1;
    for (int i = 0; i < NREQ; i++) begin
      req_reg[i*AW +: AW]  = AW'(i + 1);
      req_data[i*DW +: DW] = {$urandom, $urandom};
    end
    @(negedge clk);
    n_cmp++; if (req_ready !== 3'b000) begin n_err++; $display("FAIL reset_ready0: got %b expected 000", req_ready); end
    tick(); tick();
    @(negedge clk);
    n_cmp++; if (req_ready !== 3'b000) begin n_err++; $display("FAIL reset_ready: got %b expected 000", req_ready); end
    n_cmp++; if (RegWrite !== 1'b0) begin n_err++; $display("FAIL reset_regwrite: got %b expected 0", RegWrite); end
    n_cmp++; if (zero_drop_cnt !== 16'd0) begin n_err++; $display("FAIL reset_cnt: got %0d expected 0", zero_drop_cnt); end
    n_cmp++; if (WriteRegister !== 5'd0) begin n_err++; $display("FAIL reset_wreg: got %0d expected 0", WriteRegister); end
    n_cmp++; if (WriteData !== 64'd0) begin n_err++; $display("FAIL reset_wdata: got %h expected 0", WriteData); end
    tick();
    req_valid = '0; rst_n = 1'b1;
  endtask

  task automatic test_single_write();
    req_valid = 3'b001;
    req_reg[0 +: AW] = 5'd5;
    req_data[0 +: DW] = 64'hDEAD_BEEF;
    @(negedge clk);
    n_cmp++; if (req_ready !== 3'b001) begin n_err++; $display("FAIL single_ready: got %b expected 001", req_ready); end
    tick();
    req_valid = '0;
    @(negedge clk);
    n_cmp++; if (RegWrite !== 1'b1) begin n_err++; $display("FAIL single_we: got %b expected 1", RegWrite); end
    n_cmp++; if (WriteRegister !== 5'd5) begin n_err++; $display("FAIL single_wreg: got %0d expected 5", WriteRegister); end
    n_cmp++; if (WriteData !== 64'hDEAD_BEEF) begin n_err++; $display("FAIL single_wdata: got %h expected deadbeef", WriteData); end
    tick();
    @(negedge clk);
    n_cmp++; if (RegWrite !== 1'b0) begin n_err++; $display("FAIL single_we_off: got %b expected 0", RegWrite); end
  endtask

  task automatic test_round_robin();
    logic [DW-1:0] exp_q[$];
    logic [NREQ-1:0] exp_g;
    logic [DW-1:0] d;
    int g;
    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      req_reg[i*AW +: AW]  = AW'(10 + i);
      req_data[i*DW +: DW] = {$urandom, $urandom};
    end
    req_valid = '1;
    for (int k = 0; k <= 6; k++) begin
      @(negedge clk);
      if (k < 6) begin
        g = k % NREQ;
        exp_g = '0; exp_g[g] = 1'b1;
        n_cmp++; if (req_ready !== exp_g) begin n_err++; $display("FAIL rr_grant%0d: got %b expected %b", k, req_ready, exp_g); end
        exp_q.push_back(req_data[g*DW +: DW]);
      end
      if (k > 0) begin
        d = exp_q.pop_front();
        n_cmp++; if (RegWrite !== 1'b1) begin n_err++; $display("FAIL rr_we%0d: got %b expected 1", k, RegWrite); end
        n_cmp++; if (WriteRegister !== AW'(10 + (k - 1) % NREQ)) begin n_err++; $display("FAIL rr_wreg%0d: got %0d expected %0d", k, WriteRegister, 10 + (k - 1) % NREQ); end
        n_cmp++; if (WriteData !== d) begin n_err++; $display("FAIL rr_wdata%0d: got %h expected %h", k, WriteData, d); end
      end
      tick();
      if (k < 6) req_data[(k % NREQ)*DW +: DW] = {$urandom, $urandom};
      if (k == 5) req_valid = '0;
    end
    @(negedge clk);
    n_cmp++; if (RegWrite !== 1'b0) begin n_err++; $display("FAIL rr_we_end: got %b expected 0", RegWrite); end
  endtask

  task automatic test_zero_reg();
    do_reset();
    req_valid = 3'b010;
    req_reg[1*AW +: AW] = 5'd31;
    req_data[1*DW +: DW] = {$urandom, $urandom};
    for (int k = 0; k <= 3; k++) begin
      @(negedge clk);
      if (k < 3) begin
        n_cmp++; if (req_ready !== 3'b010) begin n_err++; $display("FAIL zero_ready%0d: got %b expected 010", k, req_ready); end
      end
      n_cmp++; if (RegWrite !== 1'b0) begin n_err++; $display("FAIL zero_we%0d: got %b expected 0", k, RegWrite); end
      tick();
      if (k == 2) req_valid = '0;
    end
    @(negedge clk);
    n_cmp++; if (zero_drop_cnt !== 16'd3) begin n_err++; $display("FAIL zero_cnt: got %0d expected 3", zero_drop_cnt); end
  endtask

  task automatic test_freeze();
    logic [DW-1:0] d;
    do_reset();
    d = {$urandom, $urandom};
    req_valid = 3'b100;
    req_reg[2*AW +: AW] = 5'd7;
    req_data[2*DW +: DW] = d;
    @(negedge clk);
    n_cmp++; if (req_ready !== 3'b100) begin n_err++; $display("FAIL freeze_grant: got %b expected 100", req_ready); end
    tick();
    arb_en = 1'b0;
    req_reg[0 +: AW] = 5'd3;
    req_reg[1*AW +: AW] = 5'd4;
    req_valid = '1;
    @(negedge clk);
    n_cmp++; if (RegWrite !== 1'b1) begin n_err++; $display("FAIL freeze_we: got %b expected 1", RegWrite); end
    n_cmp++; if (WriteRegister !== 5'd7) begin n_err++; $display("FAIL freeze_wreg: got %0d expected 7", WriteRegister); end
    n_cmp++; if (WriteData !== d) begin n_err++; $display("FAIL freeze_wdata: got %h expected %h", WriteData, d); end
    n_cmp++; if (req_ready !== 3'b000) begin n_err++; $display("FAIL freeze_ready: got %b expected 000", req_ready); end
    for (int k = 0; k < 2; k++) begin
      tick();
      @(negedge clk);
      n_cmp++; if (req_ready !== 3'b000) begin n_err++; $display("FAIL freeze_hold_ready%0d: got %b expected 000", k, req_ready); end
      n_cmp++; if (RegWrite !== 1'b0) begin n_err++; $display("FAIL freeze_hold_we%0d: got %b expected 0", k, RegWrite); end
    end
    tick();
    arb_en = 1'b1;
    @(negedge clk);
    n_cmp++; if (req_ready !== 3'b001) begin n_err++; $display("FAIL freeze_ptr: got %b expected 001", req_ready); end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    req_valid = 3'b001;
    req_reg[0 +: AW] = 5'd9;
    req_data[0 +: DW] = {$urandom, $urandom};
    @(negedge clk);
    n_cmp++; if (req_ready !== 3'b001) begin n_err++; $display("FAIL mid_grant: got %b expected 001", req_ready); end
    tick();
    rst_n = 1'b0;
    req_valid = '1;
    @(negedge clk);
    n_cmp++; if (RegWrite !== 1'b0) begin n_err++; $display("FAIL mid_we_inreset: got %b expected 0", RegWrite); end
    n_cmp++; if (req_ready !== 3'b000) begin n_err++; $display("FAIL mid_ready_inreset: got %b expected 000", req_ready); end
    tick();
    @(negedge clk);
    n_cmp++; if (RegWrite !== 1'b0) begin n_err++; $display("FAIL mid_we_after: got %b expected 0", RegWrite); end
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (req_ready !== 3'b001) begin n_err++; $display("FAIL mid_ptr: got %b expected 001", req_ready); end
  endtask

  task automatic test_random();
    logic [NREQ-1:0] exp_g;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i] && $urandom_range(0, 2) != 0) begin
          req_valid[i] = 1'b1;
          req_reg[i*AW +: AW]  = ($urandom_range(0, 3) == 0) ? 5'd31 : AW'($urandom_range(0, 31));
          req_data[i*DW +: DW] = {$urandom, $urandom};
        end
      end
      arb_en = ($urandom_range(0, 7) != 0);
      rst_n  = ($urandom_range(0, 63) != 0);
      @(negedge clk);
      exp_g = model_ready();
      n_cmp++; if (req_ready !== exp_g) begin n_err++; $display("FAIL rnd_ready c=%0d: got %b expected %b", c, req_ready, exp_g); end
      n_cmp++; if (RegWrite !== (m_we & rst_n)) begin n_err++; $display("FAIL rnd_we c=%0d: got %b expected %b", c, RegWrite, m_we & rst_n); end
      if (m_we && rst_n) begin
        n_cmp++; if (WriteRegister !== m_wr) begin n_err++; $display("FAIL rnd_wreg c=%0d: got %0d expected %0d", c, WriteRegister, m_wr); end
        n_cmp++; if (WriteData !== m_wd) begin n_err++; $display("FAIL rnd_wdata c=%0d: got %h expected %h", c, WriteData, m_wd); end
      end
      n_cmp++; if (zero_drop_cnt !== 16'(m_cnt)) begin n_err++; $display("FAIL rnd_cnt c=%0d: got %0d expected %0d", c, zero_drop_cnt, m_cnt); end
      tick();
      for (int i = 0; i < NREQ; i++) if (exp_g[i]) req_valid[i] = 1'b0;
    end
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_round_robin();
    test_zero_reg();
    test_freeze();
    test_reset_midflight();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
